calc_ctrl: RTL and testbench
============================

# calc_ctrl

Sequencing controller for the calculator datapath. Accepts a stream of key events (operand, operator, equals, clear), holds operands and function select in registers that drive the combinational `alu` directly, and registers the ALU result one cycle after equals. Supports chaining the previous result as the next operand A, and flags illegal key sequences.

## Interface
- `width`, 8, operand width; must match the `alu` instance.

- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `key_valid_i`  in  1  key event strobe; accepted when `key_valid_i && ready_o` at a rising edge.
- `key_type_i`  in  2  00 operand, 01 operator, 10 equals, 11 clear.
- `key_data_i`  in  width  operand value (type 00); `[1:0]` = function code (type 01); otherwise ignored.
- `ready_o`  out  1  controller can accept a key.
- `a_o`, `b_o`  out  width  registered operands to the ALU `a_i`/`b_i`.
- `fct_o`  out  2  registered function to the ALU `fct_i`: 00 add, 01 sub, 10 mul, 11 compare.
- `alu_s_i`  in  2*width  ALU `s_o`.
- `alu_signal_i`  in  1  ALU `signal_o`.
- `result_o`  out  2*width  captured result.
- `flag_o`  out  1  captured compare flag.
- `result_valid_o`  out  1  result/flag registers hold a fresh result.
- `error_o`  out  1  sticky sequence/overflow error.

## Operation
- States: S_A (await A), S_OP (await operator), S_B (await B), S_EQ (await equals), S_EXEC, S_DONE.
- Reset (async, `rst_ni`=0): state S_A; `a_o`, `b_o`, `fct_o`, `result_o`, `flag_o`, `result_valid_o`, `error_o` = 0; `ready_o` = 1.
- Clear (any state except S_EXEC): same values as reset, state S_A.
- S_A: operand -> A, go S_OP. Operator -> error. Equals -> ignored.
- S_OP: operand -> overwrite A. Operator -> fct, go S_B. Equals -> error.
- S_B: operand -> B, go S_EQ. Operator -> overwrite fct. Equals -> error.
- S_EQ: operand -> overwrite B. Operator -> error. Equals -> go S_EXEC.
- S_EXEC (exactly one cycle, `ready_o`=0): at the next edge, `result_o` <= `alu_s_i`, `flag_o` <= `alu_signal_i`, `result_valid_o` <= 1, go S_DONE.
- S_DONE: operand -> A, `result_valid_o` <= 0, go S_OP. Operator -> chain: if `result_o[2*width-1:width]` == 0, A <= `result_o[width-1:0]`, fct <= code, `result_valid_o` <= 0, go S_B; otherwise overflow error. Equals -> ignored.
- Error: `error_o` <= 1; state and data registers unchanged. While `error_o`=1, every key except clear is ignored.
- No sign handling: the sub result is passed through as the ALU produces it (width+1 significant bits, zero-extended). A compare result is `result_o`=0; its chain value is A=0.
- `result_o`/`flag_o` are stable except on S_EXEC capture, clear, or reset.

## Timing
- Key sampled at edge N; register and state updates are visible after edge N. There is no combinational path from key inputs to outputs.
- `ready_o` = 0 only while in S_EXEC. It is a registered state decode.
- Equals accepted at edge N: S_EXEC during cycle N..N+1. Result captured at edge N+1, with `result_valid_o`=1 and `ready_o`=1 after edge N+1. Latency is 2 edges from equals to valid.
- A key presented during S_EXEC is not accepted, including clear. The source must hold it until `ready_o`=1.
- `a_o`/`b_o`/`fct_o` are constant throughout S_EXEC, so the ALU output is settled for one full cycle before capture.
- Reset asserted mid-sequence clears all outputs immediately, without a clock edge. The first key is accepted at the first edge after release.

## Test plan
- width=8. Reset, then operand 25, operator 00, operand 17, equals -> `ready_o` low one cycle, then `result_o`=42, `flag_o`=0, `result_valid_o`=1.
- Operand 12, op 10, operand 13, equals -> 156. Then op 00 (chain), operand 44, equals -> 200, `result_valid_o` dropped between the two results.
- Operand 20, op 10, operand 20, equals -> 400 (0x0190). Then op -> `error_o`=1 and further operands ignored. Then clear -> all outputs 0, `ready_o`=1, state S_A.
- Operand 7, op 11, operand 7, equals -> `flag_o`=1, `result_o`=0. Repeat with B=8 -> `flag_o`=0.
- From reset, operator -> `error_o`=1. After clear, operand 5, operand 9 (overwrite), op 01, operand 3, equals -> `result_o`=6. Operand 5, op 00, equals in S_B -> `error_o`=1.
- `key_valid_i` held high during S_EXEC with clear -> not accepted until the next cycle. Assert `rst_ni`=0 after A captured (between edges) -> `a_o`=0, `error_o`=0, `ready_o`=1 immediately.

Source files
------------

// File: rtl/calc_ctrl.sv
// calc_ctrl: key-sequencing controller for the calculator datapath.
// Collects operand A, a function code and operand B from a key-event stream.
// The operand and function registers drive an external combinational ALU directly.
// One cycle after equals, the controller captures the ALU result and compare flag.
// A result whose upper half is zero can be chained in as the next operand A.
// An illegal key sequence sets a sticky error that only clear removes.
//
// Ports:
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   key_valid_i          key strobe, accepted when key_valid_i && ready_o at an edge
//   key_type_i[1:0]      00 operand, 01 operator, 10 equals, 11 clear
//   key_data_i[width]    operand value, or function code in [1:0]
//   ready_o              low only during the single execute cycle
//   a_o, b_o, fct_o      registered ALU operands / function select
//   alu_s_i, alu_signal_i  ALU result and compare flag
//   result_o, flag_o     captured ALU result and flag
//   result_valid_o       result/flag hold a fresh result
//   error_o              sticky sequence/overflow error
module calc_ctrl #(
  parameter int unsigned width = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               key_valid_i,
  input  logic [1:0]         key_type_i,
  input  logic [width-1:0]   key_data_i,
  output logic               ready_o,
  output logic [width-1:0]   a_o,
  output logic [width-1:0]   b_o,
  output logic [1:0]         fct_o,
  input  logic [2*width-1:0] alu_s_i,
  input  logic               alu_signal_i,
  output logic [2*width-1:0] result_o,
  output logic               flag_o,
  output logic               result_valid_o,
  output logic               error_o
);

  localparam logic [1:0] KeyOperand  = 2'b00;
  localparam logic [1:0] KeyOperator = 2'b01;
  localparam logic [1:0] KeyEquals   = 2'b10;
  localparam logic [1:0] KeyClear    = 2'b11;

  typedef enum logic [2:0] {
    StA,
    StOp,
    StB,
    StEq,
    StExec,
    StDone
  } state_t;

  state_t             r_state;
  logic [width-1:0]   r_a;
  logic [width-1:0]   r_b;
  logic [1:0]         r_fct;
  logic [2*width-1:0] r_result;
  logic               r_flag;
  logic               r_valid;
  logic               r_error;
  logic               r_ready;

  logic w_accept;
  logic w_chain_ok;

  assign w_accept   = key_valid_i && r_ready;
  // Chaining is only legal when the previous result fits in one operand.
  assign w_chain_ok = (r_result[2*width-1:width] == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= StA;
      r_a      <= '0;
      r_b      <= '0;
      r_fct    <= '0;
      r_result <= '0;
      r_flag   <= 1'b0;
      r_valid  <= 1'b0;
      r_error  <= 1'b0;
      r_ready  <= 1'b1;
    end else if (r_state == StExec) begin
      // ready_o is low here, so no key (not even clear) competes with capture.
      r_result <= alu_s_i;
      r_flag   <= alu_signal_i;
      r_valid  <= 1'b1;
      r_ready  <= 1'b1;
      r_state  <= StDone;
    end else if (w_accept) begin
      if (key_type_i == KeyClear) begin
        r_state  <= StA;
        r_a      <= '0;
        r_b      <= '0;
        r_fct    <= '0;
        r_result <= '0;
        r_flag   <= 1'b0;
        r_valid  <= 1'b0;
        r_error  <= 1'b0;
        r_ready  <= 1'b1;
      end else if (!r_error) begin
        unique case (r_state)
          StA: begin
            if (key_type_i == KeyOperand) begin
              r_a     <= key_data_i;
              r_state <= StOp;
            end else if (key_type_i == KeyOperator) begin
              r_error <= 1'b1;
            end
          end
          StOp: begin
            if (key_type_i == KeyOperand) begin
              r_a <= key_data_i;
            end else if (key_type_i == KeyOperator) begin
              r_fct   <= key_data_i[1:0];
              r_state <= StB;
            end else if (key_type_i == KeyEquals) begin
              r_error <= 1'b1;
            end
          end
          StB: begin
            if (key_type_i == KeyOperand) begin
              r_b     <= key_data_i;
              r_state <= StEq;
            end else if (key_type_i == KeyOperator) begin
              r_fct <= key_data_i[1:0];
            end else if (key_type_i == KeyEquals) begin
              r_error <= 1'b1;
            end
          end
          StEq: begin
            if (key_type_i == KeyOperand) begin
              r_b <= key_data_i;
            end else if (key_type_i == KeyOperator) begin
              r_error <= 1'b1;
            end else if (key_type_i == KeyEquals) begin
              r_ready <= 1'b0;
              r_state <= StExec;
            end
          end
          StDone: begin
            if (key_type_i == KeyOperand) begin
              r_a     <= key_data_i;
              r_valid <= 1'b0;
              r_state <= StOp;
            end else if (key_type_i == KeyOperator) begin
              if (w_chain_ok) begin
                r_a     <= r_result[width-1:0];
                r_fct   <= key_data_i[1:0];
                r_valid <= 1'b0;
                r_state <= StB;
              end else begin
                r_error <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign ready_o        = r_ready;
  assign a_o            = r_a;
  assign b_o            = r_b;
  assign fct_o          = r_fct;
  assign result_o       = r_result;
  assign flag_o         = r_flag;
  assign result_valid_o = r_valid;
  assign error_o        = r_error;

endmodule

// File: tb/tb_calc_ctrl.sv
module tb_calc_ctrl;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          key_valid = 1'b0;
  logic [1:0]    key_type = 2'b00;
  logic [W-1:0]  key_data = '0;
  logic          ready_o;
  logic [W-1:0]  a_o, b_o;
  logic [1:0]    fct_o;
  logic [2*W-1:0] alu_s;
  logic          alu_signal;
  logic [2*W-1:0] result_o;
  logic          flag_o, result_valid_o, error_o;

  int n_pass  = 0;
  int n_total = 0;

  calc_ctrl #(.width(W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .key_valid_i    (key_valid),
    .key_type_i     (key_type),
    .key_data_i     (key_data),
    .ready_o        (ready_o),
    .a_o            (a_o),
    .b_o            (b_o),
    .fct_o          (fct_o),
    .alu_s_i        (alu_s),
    .alu_signal_i   (alu_signal),
    .result_o       (result_o),
    .flag_o         (flag_o),
    .result_valid_o (result_valid_o),
    .error_o        (error_o)
  );

  always #5 clk = ~clk;

  // ALU stand-in driven by the controller's registered operands.
  always_comb begin
    alu_signal = 1'b0;
    alu_s      = '0;
    case (fct_o)
      2'd0: alu_s = 16'(a_o) + 16'(b_o);
      2'd1: alu_s = {7'd0, 9'({1'b0, a_o} - {1'b0, b_o})};
      2'd2: alu_s = 16'(a_o) * 16'(b_o);
      default: alu_signal = (a_o == b_o);
    endcase
  end

  // Reference model: what the controller should be holding after each accepted key.
  int            m_phase;  // 0 want A, 1 want op, 2 want B, 3 want equals, 4 have result
  logic [W-1:0]  m_a, m_b;
  logic [1:0]    m_fct;
  logic [2*W-1:0] m_res;
  logic          m_flag, m_rv, m_err;

  function automatic logic [2*W-1:0] ref_result(input int a, input int b, input int f);
    int r;
    case (f)
      0:       r = a + b;
      1:       r = (a - b + 512) % 512;
      2:       r = a * b;
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  task automatic model_key(input logic [1:0] t, input logic [W-1:0] d);
    if (t == 2'd3) begin
      m_phase = 0; m_a = 0; m_b = 0; m_fct = 0; m_res = 0;
      m_flag = 0; m_rv = 0; m_err = 0;
    end else if (!m_err) begin
      case (m_phase)
        0: if (t == 0) begin m_a = d; m_phase = 1; end
           else if (t == 1) m_err = 1;
        1: if (t == 0) m_a = d;
           else if (t == 1) begin m_fct = d[1:0]; m_phase = 2; end
           else m_err = 1;
        2: if (t == 0) begin m_b = d; m_phase = 3; end
           else if (t == 1) m_fct = d[1:0];
           else m_err = 1;
        3: if (t == 0) m_b = d;
           else if (t == 1) m_err = 1;
           else begin
             m_res  = ref_result(int'(m_a), int'(m_b), int'(m_fct));
             m_flag = (m_fct == 3) && (m_a == m_b);
             m_rv   = 1;
             m_phase = 4;
           end
        default:
          if (t == 0) begin m_a = d; m_rv = 0; m_phase = 1; end
          else if (t == 1) begin
            if (m_res < 256) begin
              m_a = m_res[W-1:0]; m_fct = d[1:0]; m_rv = 0; m_phase = 2;
            end else m_err = 1;
          end
      endcase
    end
  endtask

  task automatic press(input logic [1:0] t, input logic [W-1:0] d);
    int n = 0;
    while (!ready_o && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) begin
      n_total++;
      $display("FAIL press_timeout ready_o=%b required 1", ready_o);
    end
    key_valid = 1'b1; key_type = t; key_data = d;
    @(posedge clk); #1;
    key_valid = 1'b0;
    model_key(t, d);
  endtask

  task automatic settle();
    if (!ready_o) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    model_key(2'd3, '0);
    n_total++;
    if ({a_o, b_o, fct_o, result_o, flag_o, result_valid_o, error_o, ready_o} !== {42'd0, 1'b1})
      $display("FAIL reset_state got a=%0d b=%0d f=%0d r=%0d fl=%b rv=%b e=%b rdy=%b required 0s rdy=1",
               a_o, b_o, fct_o, result_o, flag_o, result_valid_o, error_o, ready_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    press(0, 25); press(1, 0); press(0, 17); press(2, 0);
    n_total++;
    if (ready_o !== 1'b0) $display("FAIL add_exec_ready got %b required 0", ready_o);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({result_o, flag_o, result_valid_o, ready_o} !== {16'd42, 1'b0, 1'b1, 1'b1})
      $display("FAIL add_result got r=%0d fl=%b rv=%b rdy=%b required 42 0 1 1",
               result_o, flag_o, result_valid_o, ready_o);
    else n_pass++;
  endtask

  task automatic test_mul_chain();
    press(0, 12); press(1, 2); press(0, 13); press(2, 0); settle();
    n_total++;
    if ({result_o, result_valid_o} !== {16'd156, 1'b1})
      $display("FAIL mul_result got r=%0d rv=%b required 156 1", result_o, result_valid_o);
    else n_pass++;
    press(1, 0);
    n_total++;
    if ({a_o, fct_o, result_valid_o, error_o} !== {8'd156, 2'd0, 1'b0, 1'b0})
      $display("FAIL chain_load got a=%0d f=%0d rv=%b e=%b required 156 0 0 0",
               a_o, fct_o, result_valid_o, error_o);
    else n_pass++;
    press(0, 44); press(2, 0); settle();
    n_total++;
    if ({result_o, result_valid_o} !== {16'd200, 1'b1})
      $display("FAIL chain_result got r=%0d rv=%b required 200 1", result_o, result_valid_o);
    else n_pass++;
  endtask

  task automatic test_overflow();
    press(3, 0);
    press(0, 20); press(1, 2); press(0, 20); press(2, 0); settle();
    n_total++;
    if (result_o !== 16'h0190) $display("FAIL ovf_result got %h required 0190", result_o);
    else n_pass++;
    press(1, 0);
    n_total++;
    if ({error_o, a_o} !== {1'b1, 8'd20})
      $display("FAIL ovf_chain_error got e=%b a=%0d required 1 20", error_o, a_o);
    else n_pass++;
    press(0, 5);
    n_total++;
    if ({error_o, a_o, result_o} !== {1'b1, 8'd20, 16'h0190})
      $display("FAIL ovf_ignore got e=%b a=%0d r=%h required 1 20 0190", error_o, a_o, result_o);
    else n_pass++;
    press(3, 0);
    n_total++;
    if ({a_o, b_o, fct_o, result_o, flag_o, result_valid_o, error_o, ready_o} !== {42'd0, 1'b1})
      $display("FAIL clear_state got a=%0d b=%0d f=%0d r=%0d e=%b rdy=%b required 0s rdy=1",
               a_o, b_o, fct_o, result_o, error_o, ready_o);
    else n_pass++;
    press(1, 0);  // operator right after clear must be illegal (awaiting A)
    n_total++;
    if (error_o !== 1'b1) $display("FAIL clear_to_sa got e=%b required 1", error_o);
    else n_pass++;
    press(3, 0);
  endtask

  task automatic test_compare();
    press(0, 7); press(1, 3); press(0, 7); press(2, 0); settle();
    n_total++;
    if ({flag_o, result_o, result_valid_o} !== {1'b1, 16'd0, 1'b1})
      $display("FAIL cmp_equal got fl=%b r=%0d rv=%b required 1 0 1", flag_o, result_o, result_valid_o);
    else n_pass++;
    press(0, 7); press(1, 3); press(0, 8); press(2, 0); settle();
    n_total++;
    if ({flag_o, result_o} !== {1'b0, 16'd0})
      $display("FAIL cmp_differ got fl=%b r=%0d required 0 0", flag_o, result_o);
    else n_pass++;
  endtask

  task automatic test_errors();
    press(3, 0); press(1, 0);
    n_total++;
    if (error_o !== 1'b1) $display("FAIL err_op_in_a got %b required 1", error_o);
    else n_pass++;
    press(3, 0);
    press(0, 5); press(0, 9); press(1, 1); press(0, 3); press(2, 0); settle();
    n_total++;
    if ({result_o, a_o, error_o} !== {16'd6, 8'd9, 1'b0})
      $display("FAIL sub_overwrite got r=%0d a=%0d e=%b required 6 9 0", result_o, a_o, error_o);
    else n_pass++;
    press(0, 5); press(1, 0); press(2, 0);
    n_total++;
    if (error_o !== 1'b1) $display("FAIL err_eq_in_b got %b required 1", error_o);
    else n_pass++;
    press(3, 0);
  endtask

  task automatic test_exec_hold();
    press(0, 3); press(1, 0); press(0, 4); press(2, 0);
    key_valid = 1'b1; key_type = 2'd3; key_data = '0;
    n_total++;
    if (ready_o !== 1'b0) $display("FAIL hold_ready got %b required 0", ready_o);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if ({result_o, result_valid_o} !== {16'd7, 1'b1})
      $display("FAIL hold_not_cleared got r=%0d rv=%b required 7 1", result_o, result_valid_o);
    else n_pass++;
    @(posedge clk); #1;
    key_valid = 1'b0;
    model_key(2'd3, '0);
    n_total++;
    if ({result_o, result_valid_o, a_o} !== {16'd0, 1'b0, 8'd0})
      $display("FAIL hold_cleared got r=%0d rv=%b a=%0d required 0 0 0", result_o, result_valid_o, a_o);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    press(0, 9); press(2, 0);
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({a_o, error_o, ready_o} !== {8'd0, 1'b0, 1'b1})
      $display("FAIL async_reset got a=%0d e=%b rdy=%b required 0 0 1", a_o, error_o, ready_o);
    else n_pass++;
    model_key(2'd3, '0);
    @(negedge clk);
    rst_n = 1'b1;
    press(0, 4);
    n_total++;
    if (a_o !== 8'd4) $display("FAIL first_key_after_reset got a=%0d required 4", a_o);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [1:0] t;
    logic [W-1:0] d;
    int r;
    press(3, 0);
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 15));
      t = (r == 0) ? 2'd3 : 2'(r % 3);
      d = W'($urandom);
      press(t, d);
      settle();
      n_total++;
      if ({a_o, b_o, fct_o, result_o, flag_o, result_valid_o, error_o} !==
          {m_a, m_b, m_fct, m_res, m_flag, m_rv, m_err})
        $display("FAIL random_%0d key=%0d got a=%0d b=%0d f=%0d r=%0d fl=%b rv=%b e=%b required a=%0d b=%0d f=%0d r=%0d fl=%b rv=%b e=%b",
                 i, t, a_o, b_o, fct_o, result_o, flag_o, result_valid_o, error_o,
                 m_a, m_b, m_fct, m_res, m_flag, m_rv, m_err);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_chain();
    test_overflow();
    test_compare();
    test_errors();
    test_exec_hold();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
